// File: rtl/sym_result_buffer.sv
// rtl/sym_result_buffer.sv - upper-triangle result store streaming the mirrored NxN matrix
// Purpose: collects NPORT MAC results into upper-triangle slots and streams the full
//          symmetric matrix row-major over a valid/ready interface.
// Ports:   clk_i, aclr_i (async active-high reset), clr_i (sync clear)
//          wr_en_i/wr_row_i/wr_col_i/wr_data_i : packed per-port write interface
//          start_i : begin streaming; dout_o/dout_valid_o/dout_ready_i/dout_last_o : stream
//          done_o : pulse after last beat; busy_o : streaming; all_wr_o : all slots written
// Option:  SRB_OVERWRITE_FLAG_EN adds ovw_err_o, a sticky flag for writes to written slots.
module sym_result_buffer #(
    parameter int DW    = 16,
    parameter int N     = 4,
    parameter int NPORT = 2
) (
    input  logic               clk_i,
    input  logic               aclr_i,
    input  logic               clr_i,
    input  logic [NPORT-1:0]   wr_en_i,
    input  logic [NPORT*4-1:0] wr_row_i,
    input  logic [NPORT*4-1:0] wr_col_i,
    input  logic [NPORT*DW-1:0] wr_data_i,
    input  logic               start_i,
    output logic [DW-1:0]      dout_o,
    output logic               dout_valid_o,
    input  logic               dout_ready_i,
    output logic               dout_last_o,
    output logic               done_o,
    output logic               busy_o,
    output logic               all_wr_o
`ifdef SRB_OVERWRITE_FLAG_EN
    ,
    output logic               ovw_err_o
`endif
);

    localparam int NS = N * (N + 1) / 2;
    localparam int SW = $clog2(NS);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    // Row-major packing of the upper triangle: row lo starts after the lo longer rows above it.
    function automatic logic [SW-1:0] slot_idx(input logic [3:0] r, input logic [3:0] c);
        int lo;
        int hi;
        int s;
        lo = (r < c) ? int'(r) : int'(c);
        hi = (r < c) ? int'(c) : int'(r);
        s  = lo * N - (lo * (lo - 1)) / 2 + (hi - lo);
        return SW'(s);
    endfunction

    logic [DW-1:0] mem_q [NS];
    logic [DW-1:0] mem_d [NS];
    logic [NS-1:0] wmap_q, wmap_d;
    logic          all_wr_q, all_wr_d;
    logic [3:0]    wr_r, wr_c;
    logic [SW-1:0] wr_idx;
`ifdef SRB_OVERWRITE_FLAG_EN
    logic          ovw_q, ovw_d;
`endif

    state_t        state_q, state_d;
    logic [3:0]    i_q, i_d, j_q, j_d, ni, nj;
    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d, last_q, last_d, done_q, done_d;

    // Storage update; later ports overwrite earlier ones so the highest port wins a collision.
    always_comb begin
        mem_d  = mem_q;
        wmap_d = wmap_q;
        wr_r   = '0;
        wr_c   = '0;
        wr_idx = '0;
`ifdef SRB_OVERWRITE_FLAG_EN
        ovw_d  = ovw_q;
`endif
        if (clr_i) begin
            for (int k = 0; k < NS; k++) mem_d[k] = '0;
            wmap_d = '0;
`ifdef SRB_OVERWRITE_FLAG_EN
            ovw_d  = 1'b0;
`endif
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                wr_r = wr_row_i[4*p +: 4];
                wr_c = wr_col_i[4*p +: 4];
                if (wr_en_i[p] && int'(wr_r) < N && int'(wr_c) < N) begin
                    wr_idx = slot_idx(wr_r, wr_c);
`ifdef SRB_OVERWRITE_FLAG_EN
                    // wmap_d already holds earlier ports of this cycle, so collisions flag too.
                    if (wmap_d[wr_idx]) ovw_d = 1'b1;
`endif
                    mem_d[wr_idx]  = wr_data_i[DW*p +: DW];
                    wmap_d[wr_idx] = 1'b1;
                end
            end
        end
        all_wr_d = &wmap_d;
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        ni      = '0;
        nj      = '0;
        if (clr_i) begin
            state_d = S_IDLE;
            i_d     = '0;
            j_d     = '0;
            dout_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_STREAM;
                        i_d     = '0;
                        j_d     = '0;
                        dout_d  = mem_q[slot_idx(4'd0, 4'd0)];
                        valid_d = 1'b1;
                        last_d  = 1'b0;
                    end
                end
                S_STREAM: begin
                    if (valid_q && dout_ready_i) begin
                        if (last_q) begin
                            state_d = S_IDLE;
                            dout_d  = '0;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            if (j_q == 4'(N - 1)) begin
                                ni = i_q + 4'd1;
                                nj = '0;
                            end else begin
                                ni = i_q;
                                nj = j_q + 4'd1;
                            end
                            i_d    = ni;
                            j_d    = nj;
                            // Captured here so later writes to this slot leave the held beat alone.
                            dout_d = mem_q[slot_idx(ni, nj)];
                            last_d = (ni == 4'(N - 1)) && (nj == 4'(N - 1));
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            for (int k = 0; k < NS; k++) mem_q[k] <= '0;
            wmap_q   <= '0;
            all_wr_q <= 1'b0;
`ifdef SRB_OVERWRITE_FLAG_EN
            ovw_q    <= 1'b0;
`endif
            state_q  <= S_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            for (int k = 0; k < NS; k++) mem_q[k] <= mem_d[k];
            wmap_q   <= wmap_d;
            all_wr_q <= all_wr_d;
`ifdef SRB_OVERWRITE_FLAG_EN
            ovw_q    <= ovw_d;
`endif
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign dout_last_o  = last_q;
    assign done_o       = done_q;
    assign busy_o       = (state_q == S_STREAM);
    assign all_wr_o     = all_wr_q;
`ifdef SRB_OVERWRITE_FLAG_EN
    assign ovw_err_o    = ovw_q;
`endif

endmodule
